id_ex_operand_stage: RTL and testbench

- ID/EX pipeline register directly upstream of the ALU in the 5-stage MIPS pipeline.
- Captures decoded operands and control at the ID/EX boundary.
- Resolves EX/MEM and MEM/WB forwarding and the ALUSrc select, then drives the ALU inputs Read_Data_1, Alu_Src_Output and ALUctrl.
- Detects load-use hazards and inserts one bubble per hazard.

---
 rtl/mips_pkg.sv | 27 ++
 rtl/id_ex_operand_stage_fwd_mux.sv | 33 +++
 rtl/id_ex_operand_stage.sv | 154 +++++++++++++++
 tb/tb_id_ex_operand_stage.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: datapath widths, ALU opcodes and the
// ID/EX control bundle with its bubble value.
package mips_pkg;

    localparam int MIPS_DATA_W = 32;
    localparam int MIPS_REG_AW = 5;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic [3:0] alu_ctrl;
    } ctrl_t;

    // A bubble writes nothing and presents AND to the ALU.
    localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_operand_stage_fwd_mux.sv
// Operand forwarding select for one source register; EX/MEM wins over MEM/WB
// and $0 is never forwarded.
module fwd_mux #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] src_reg_i,
    input  logic [DATA_W-1:0] rf_data_i,
    input  logic              exmem_reg_write_i,
    input  logic [REG_AW-1:0] exmem_rd_i,
    input  logic [DATA_W-1:0] exmem_result_i,
    input  logic              memwb_reg_write_i,
    input  logic [REG_AW-1:0] memwb_rd_i,
    input  logic [DATA_W-1:0] memwb_result_i,
    output logic [DATA_W-1:0] fwd_data_o
);

    logic exmem_hit;
    logic memwb_hit;

    assign exmem_hit = exmem_reg_write_i && (exmem_rd_i != '0) && (exmem_rd_i == src_reg_i);
    assign memwb_hit = memwb_reg_write_i && (memwb_rd_i != '0) && (memwb_rd_i == src_reg_i);

    always_comb begin
        fwd_data_o = rf_data_i;
        if (exmem_hit) begin
            fwd_data_o = exmem_result_i;
        end else if (memwb_hit) begin
            fwd_data_o = memwb_result_i;
        end
    end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register feeding the ALU: captures decoded operands, resolves
// forwarding and ALUSrc, and inserts a one-cycle bubble on a load-use hazard.
module id_ex_operand_stage
    import mips_pkg::*;
#(
    parameter int DATA_W = MIPS_DATA_W,
    parameter int REG_AW = MIPS_REG_AW
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_uses_rt,
    input  logic [3:0]        id_alu_ctrl,
    input  logic              id_alu_src,
    input  logic              id_reg_dst,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              id_mem_to_reg,
    input  logic              stall,
    input  logic              flush,
    input  logic              exmem_reg_write,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic [DATA_W-1:0] exmem_result,
    input  logic              memwb_reg_write,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic [DATA_W-1:0] memwb_result,
    output logic              load_use_hazard,
    output logic              ex_valid,
    output logic [DATA_W-1:0] Read_Data_1,
    output logic [DATA_W-1:0] Alu_Src_Output,
    output logic [3:0]        ALUctrl,
    output logic [DATA_W-1:0] ex_store_data,
    output logic [REG_AW-1:0] ex_dest,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_mem_to_reg
);

    logic              valid_q,   valid_d;
    ctrl_t             ctrl_q,    ctrl_d;
    logic [REG_AW-1:0] rs_q,      rs_d;
    logic [REG_AW-1:0] rt_q,      rt_d;
    logic [REG_AW-1:0] dest_q,    dest_d;
    logic [DATA_W-1:0] rs_data_q, rs_data_d;
    logic [DATA_W-1:0] rt_data_q, rt_data_d;
    logic [DATA_W-1:0] imm_q,     imm_d;
    logic [DATA_W-1:0] fwd_rs;
    logic [DATA_W-1:0] fwd_rt;

    // Only a live load in EX can stall the consumer in ID; stall does not mask it.
    assign load_use_hazard = valid_q && ctrl_q.mem_read && (dest_q != '0) && id_valid &&
                             ((dest_q == id_rs) || (id_uses_rt && (dest_q == id_rt)));

    always_comb begin
        valid_d   = valid_q;
        ctrl_d    = ctrl_q;
        rs_d      = rs_q;
        rt_d      = rt_q;
        dest_d    = dest_q;
        rs_data_d = rs_data_q;
        rt_data_d = rt_data_q;
        imm_d     = imm_q;
        if (flush || (!stall && load_use_hazard)) begin
            valid_d   = 1'b0;
            ctrl_d    = CTRL_BUBBLE;
            rs_d      = '0;
            rt_d      = '0;
            dest_d    = '0;
            rs_data_d = '0;
            rt_data_d = '0;
            imm_d     = '0;
        end else if (!stall) begin
            valid_d           = id_valid;
            ctrl_d.reg_write  = id_reg_write  && id_valid;
            ctrl_d.mem_read   = id_mem_read   && id_valid;
            ctrl_d.mem_write  = id_mem_write  && id_valid;
            ctrl_d.mem_to_reg = id_mem_to_reg && id_valid;
            ctrl_d.alu_src    = id_alu_src;
            ctrl_d.alu_ctrl   = id_alu_ctrl;
            rs_d              = id_rs;
            rt_d              = id_rt;
            dest_d            = id_reg_dst ? id_rd : id_rt;
            rs_data_d         = id_rs_data;
            rt_data_d         = id_rt_data;
            imm_d             = id_imm;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q   <= 1'b0;
            ctrl_q    <= CTRL_BUBBLE;
            rs_q      <= '0;
            rt_q      <= '0;
            dest_q    <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
        end else begin
            valid_q   <= valid_d;
            ctrl_q    <= ctrl_d;
            rs_q      <= rs_d;
            rt_q      <= rt_d;
            dest_q    <= dest_d;
            rs_data_q <= rs_data_d;
            rt_data_q <= rt_data_d;
            imm_q     <= imm_d;
        end
    end

    fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rs (
        .src_reg_i        (rs_q),
        .rf_data_i        (rs_data_q),
        .exmem_reg_write_i(exmem_reg_write),
        .exmem_rd_i       (exmem_rd),
        .exmem_result_i   (exmem_result),
        .memwb_reg_write_i(memwb_reg_write),
        .memwb_rd_i       (memwb_rd),
        .memwb_result_i   (memwb_result),
        .fwd_data_o       (fwd_rs)
    );

    fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rt (
        .src_reg_i        (rt_q),
        .rf_data_i        (rt_data_q),
        .exmem_reg_write_i(exmem_reg_write),
        .exmem_rd_i       (exmem_rd),
        .exmem_result_i   (exmem_result),
        .memwb_reg_write_i(memwb_reg_write),
        .memwb_rd_i       (memwb_rd),
        .memwb_result_i   (memwb_result),
        .fwd_data_o       (fwd_rt)
    );

    assign ex_valid       = valid_q;
    assign Read_Data_1    = fwd_rs;
    assign ex_store_data  = fwd_rt;
    assign Alu_Src_Output = ctrl_q.alu_src ? imm_q : fwd_rt;
    assign ALUctrl        = ctrl_q.alu_ctrl;
    assign ex_dest        = dest_q;
    assign ex_reg_write   = ctrl_q.reg_write;
    assign ex_mem_read    = ctrl_q.mem_read;
    assign ex_mem_write   = ctrl_q.mem_write;
    assign ex_mem_to_reg  = ctrl_q.mem_to_reg;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Scoreboard bench for id_ex_operand_stage: a reference EX-register model is
// queued each cycle and compared against the DUT's outputs on the next.
module tb_id_ex_operand_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic        id_uses_rt;
    logic [3:0]  id_alu_ctrl;
    logic        id_alu_src, id_reg_dst;
    logic        id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
    logic        stall, flush;
    logic        exmem_reg_write;
    logic [4:0]  exmem_rd;
    logic [31:0] exmem_result;
    logic        memwb_reg_write;
    logic [4:0]  memwb_rd;
    logic [31:0] memwb_result;
    logic        load_use_hazard, ex_valid;
    logic [31:0] Read_Data_1, Alu_Src_Output, ex_store_data;
    logic [3:0]  ALUctrl;
    logic [4:0]  ex_dest;
    logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;

    typedef struct packed {
        logic        valid;
        logic        regWrite;
        logic        memRead;
        logic        memWrite;
        logic        memToReg;
        logic        aluSrc;
        logic [3:0]  aluCtrl;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  dest;
        logic [31:0] rsData;
        logic [31:0] rtData;
        logic [31:0] imm;
    } exModel_t;

    exModel_t modelQ;
    exModel_t expQueue[$];
    int testCount = 0;
    int failCount = 0;

    always #5 clk = ~clk;

    id_ex_operand_stage dut (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_uses_rt(id_uses_rt),
        .id_alu_ctrl(id_alu_ctrl), .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
        .stall(stall), .flush(flush),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .load_use_hazard(load_use_hazard), .ex_valid(ex_valid),
        .Read_Data_1(Read_Data_1), .Alu_Src_Output(Alu_Src_Output), .ALUctrl(ALUctrl),
        .ex_store_data(ex_store_data), .ex_dest(ex_dest),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    function automatic logic [31:0] fwdModel(input logic [4:0] r, input logic [31:0] raw);
        if (exmem_reg_write && exmem_rd != 5'd0 && exmem_rd == r) return exmem_result;
        if (memwb_reg_write && memwb_rd != 5'd0 && memwb_rd == r) return memwb_result;
        return raw;
    endfunction

    function automatic logic hazardModel();
        return modelQ.valid && modelQ.memRead && modelQ.dest != 5'd0 && id_valid &&
               (modelQ.dest == id_rs || (id_uses_rt && modelQ.dest == id_rt));
    endfunction

    function automatic exModel_t nextModel();
        exModel_t n;
        n = modelQ;
        if (reset || flush || (!stall && hazardModel())) begin
            n = '0;
        end else if (!stall) begin
            n.valid    = id_valid;
            n.regWrite = id_reg_write & id_valid;
            n.memRead  = id_mem_read & id_valid;
            n.memWrite = id_mem_write & id_valid;
            n.memToReg = id_mem_to_reg & id_valid;
            n.aluSrc   = id_alu_src;
            n.aluCtrl  = id_alu_ctrl;
            n.rs       = id_rs;
            n.rt       = id_rt;
            n.dest     = id_reg_dst ? id_rd : id_rt;
            n.rsData   = id_rs_data;
            n.rtData   = id_rt_data;
            n.imm      = id_imm;
        end
        return n;
    endfunction

    task automatic checkCycle(input string tag);
        logic [31:0] expRt;
        expRt = fwdModel(modelQ.rt, modelQ.rtData);
        checkOutput({tag, "_hazard"}, 32'(load_use_hazard), 32'(hazardModel()));
        checkOutput({tag, "_valid"},  32'(ex_valid),        32'(modelQ.valid));
        checkOutput({tag, "_rd1"},    Read_Data_1,          fwdModel(modelQ.rs, modelQ.rsData));
        checkOutput({tag, "_srcB"},   Alu_Src_Output,       modelQ.aluSrc ? modelQ.imm : expRt);
        checkOutput({tag, "_store"},  ex_store_data,        expRt);
        checkOutput({tag, "_aluctl"}, 32'(ALUctrl),         32'(modelQ.aluCtrl));
        checkOutput({tag, "_dest"},   32'(ex_dest),         32'(modelQ.dest));
        checkOutput({tag, "_ctrl"},
                    32'({ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg}),
                    32'({modelQ.regWrite, modelQ.memRead, modelQ.memWrite, modelQ.memToReg}));
    endtask

    // One clock: check the current EX state, queue the predicted next state, advance.
    task automatic applyStimulus(input string tag);
        #1;
        checkCycle(tag);
        expQueue.push_back(nextModel());
        @(posedge clk);
        modelQ = expQueue.pop_front();
        @(negedge clk);
    endtask

    task automatic clearInputs();
        reset = 0; id_valid = 0; id_rs_data = 0; id_rt_data = 0; id_imm = 0;
        id_rs = 0; id_rt = 0; id_rd = 0; id_uses_rt = 0; id_alu_ctrl = 0;
        id_alu_src = 0; id_reg_dst = 0; id_reg_write = 0; id_mem_read = 0;
        id_mem_write = 0; id_mem_to_reg = 0; stall = 0; flush = 0;
        exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
        memwb_reg_write = 0; memwb_rd = 0; memwb_result = 0;
    endtask

    task automatic setInstr(input logic [4:0] rs, input logic [31:0] rsData,
                            input logic [4:0] rt, input logic [31:0] rtData,
                            input logic [4:0] rd, input logic [3:0] ctl,
                            input logic useRt, input logic lw);
        id_valid = 1; id_rs = rs; id_rs_data = rsData; id_rt = rt; id_rt_data = rtData;
        id_rd = rd; id_alu_ctrl = ctl; id_uses_rt = useRt; id_alu_src = lw;
        id_reg_dst = !lw; id_reg_write = 1; id_mem_read = lw; id_mem_to_reg = lw;
        id_mem_write = 0; id_imm = 32'd4;
    endtask

    initial begin
        clearInputs();
        reset = 1;
        @(posedge clk);
        @(negedge clk);
        modelQ = '0;
        applyStimulus("reset");
        reset = 0;
        checkOutput("reset_rd1", Read_Data_1, 32'd0);

        // Plain capture of add $3,$1,$2
        setInstr(5'd1, 32'd50, 5'd2, 32'd20, 5'd3, 4'b0010, 1, 0);
        applyStimulus("add");
        id_valid = 0;
        #1;
        checkOutput("add_rd1", Read_Data_1, 32'd50);
        checkOutput("add_srcB", Alu_Src_Output, 32'd20);
        checkOutput("add_dest", 32'(ex_dest), 32'd3);
        checkOutput("add_rw", 32'(ex_reg_write), 32'd1);

        // Immediate operand B
        setInstr(5'd1, 32'd50, 5'd2, 32'd7, 5'd3, 4'b0010, 1, 0);
        id_alu_src = 1; id_imm = 32'hFFFF_FFFC;
        applyStimulus("imm");
        id_valid = 0;
        #1;
        checkOutput("imm_srcB", Alu_Src_Output, 32'hFFFF_FFFC);
        checkOutput("imm_store", ex_store_data, 32'd7);

        // Forwarding priority on rs=5, EX held by stall
        setInstr(5'd5, 32'd11, 5'd6, 32'd12, 5'd7, 4'b0110, 1, 0);
        applyStimulus("fwd_cap");
        id_valid = 0; stall = 1;
        exmem_reg_write = 1; exmem_rd = 5'd5; exmem_result = 32'd100;
        memwb_reg_write = 1; memwb_rd = 5'd5; memwb_result = 32'd200;
        #1 checkOutput("fwd_exmem", Read_Data_1, 32'd100);
        applyStimulus("fwd_both");
        exmem_reg_write = 0;
        #1 checkOutput("fwd_memwb", Read_Data_1, 32'd200);
        applyStimulus("fwd_mw");
        stall = 0;
        setInstr(5'd0, 32'd77, 5'd0, 32'd66, 5'd9, 4'b0001, 1, 0);
        exmem_reg_write = 1; exmem_rd = 5'd0; memwb_rd = 5'd0;
        applyStimulus("fwd_r0cap");
        id_valid = 0;
        #1 checkOutput("fwd_r0", Read_Data_1, 32'd77);
        exmem_reg_write = 0; memwb_reg_write = 0;

        // Load-use on rs
        setInstr(5'd1, 32'd1, 5'd8, 32'd0, 5'd0, 4'b0010, 0, 1);
        applyStimulus("lw");
        setInstr(5'd8, 32'd5, 5'd2, 32'd6, 5'd10, 4'b0010, 1, 0);
        #1 checkOutput("lu_hazard", 32'(load_use_hazard), 32'd1);
        applyStimulus("lu_hz");
        #1 checkOutput("lu_bubble", 32'(ex_valid), 32'd0);
        checkOutput("lu_drop", 32'(load_use_hazard), 32'd0);
        applyStimulus("lu_cap");
        checkOutput("lu_captured", 32'(ex_dest), 32'd10);

        // rt match without uses_rt is not a hazard
        setInstr(5'd1, 32'd1, 5'd8, 32'd0, 5'd0, 4'b0010, 0, 1);
        applyStimulus("lw2");
        setInstr(5'd1, 32'd5, 5'd8, 32'd6, 5'd11, 4'b0010, 0, 0);
        #1 checkOutput("lu_nort", 32'(load_use_hazard), 32'd0);
        id_uses_rt = 1;
        #1 checkOutput("lu_rt", 32'(load_use_hazard), 32'd1);
        id_uses_rt = 0;
        applyStimulus("lu_nort");

        // Stall for 3 cycles, then stall with flush
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            setInstr(5'(i + 12), 32'(i), 5'd2, 32'd3, 5'd4, 4'b0111, 1, 0);
            applyStimulus("stall");
        end
        #1 checkOutput("stall_dest", 32'(ex_dest), 32'd11);
        flush = 1;
        applyStimulus("stflush");
        #1 checkOutput("stflush_valid", 32'(ex_valid), 32'd0);
        stall = 0; flush = 0;

        // Reset while a load is held under stall with a pending hazard
        setInstr(5'd1, 32'd1, 5'd8, 32'd0, 5'd0, 4'b0010, 0, 1);
        applyStimulus("rst_lw");
        setInstr(5'd8, 32'd5, 5'd2, 32'd6, 5'd10, 4'b1100, 1, 0);
        stall = 1; reset = 1;
        applyStimulus("rst_mid");
        #1 checkOutput("rst_valid", 32'(ex_valid), 32'd0);
        checkOutput("rst_hazard", 32'(load_use_hazard), 32'd0);
        reset = 0; stall = 0;

        // Random traffic over a small register range
        for (int n = 0; n < 300; n++) begin
            id_valid = ($urandom_range(0, 9) != 0);
            id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
            id_rd = 5'($urandom_range(0, 3));
            id_rs_data = $urandom; id_rt_data = $urandom; id_imm = $urandom;
            id_uses_rt = 1'($urandom); id_alu_ctrl = 4'($urandom);
            id_alu_src = 1'($urandom); id_reg_dst = 1'($urandom);
            id_reg_write = 1'($urandom); id_mem_read = 1'($urandom);
            id_mem_write = 1'($urandom); id_mem_to_reg = 1'($urandom);
            stall = ($urandom_range(0, 4) == 0); flush = ($urandom_range(0, 9) == 0);
            reset = ($urandom_range(0, 39) == 0);
            exmem_reg_write = 1'($urandom); exmem_rd = 5'($urandom_range(0, 3));
            exmem_result = $urandom;
            memwb_reg_write = 1'($urandom); memwb_rd = 5'($urandom_range(0, 3));
            memwb_result = $urandom;
            applyStimulus("rand");
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
